fir_driver: RTL
===============

FIR_DRIVER -- requirements
Module: fir_driver

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 16, sample/coef/result width; NUM_REGS, 8, filter taps; RES_DEPTH, 4, result FIFO entries (>=4).
REQ-002 Ports (name  direction  width  meaning), in this order: clk  in  1  single clock; rstN  in  1  reset, synchronous, active-low.
REQ-003 coefWrEn  in  1  coefficient write strobe; coefAddr  in  clog2(NUM_REGS)  tap index; coefData  in  DATA_WIDTH  tap value.
REQ-004 start  in  1  pulse, IDLE->RUN; stop  in  1  pulse, RUN->DRAIN.
REQ-005 sampleValid  in  1; sampleData  in  DATA_WIDTH; sampleReady  out  1  (sample stream, valid/ready).
REQ-006 rawSensorVal  out  DATA_WIDTH; coefs  out  NUM_REGS x DATA_WIDTH; accelerateEn  out  1  (to accelerator).
REQ-007 macResult  in  DATA_WIDTH; resultIsValid  in  1  (from accelerator).
REQ-008 resValid  out  1; resData  out  DATA_WIDTH; resReady  in  1  (result stream); busy  out  1  state!=IDLE; err  out  1  sticky error.

Function
REQ-009 States IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on stop; DRAIN->IDLE when inFlight==0; start outside IDLE and stop outside RUN are ignored.
REQ-010 Coef write in IDLE: coefs[coefAddr]<=coefData at next edge; coefAddr>=NUM_REGS ignored and sets err.
REQ-011 Coef write in RUN/DRAIN is ignored (coefs unchanged) and sets err.
REQ-012 sampleReady = (state==RUN) && (fifoCount+inFlight < RES_DEPTH), combinational; sample accepted on sampleValid&&sampleReady.
REQ-013 Accepted sample at edge k: rawSensorVal<=sampleData, accelerateEn<=1 at edge k; accelerator result expected on resultIsValid after edge k+2.
REQ-014 Cycles without acceptance: rawSensorVal<=0, accelerateEn<=0 (zero-fill; filter history includes these zeros).
REQ-015 inFlight counter: +1 on acceptance, -1 when resultIsValid sampled high; both same cycle -> unchanged; range 0..3.
REQ-016 resultIsValid high with inFlight==0: result discarded, err set, counter unchanged.
REQ-017 Result FIFO: push macResult on counted resultIsValid; pop on resValid&&resReady; resValid=!empty; resData=head; order preserved.
REQ-018 Credit rule (REQ-012) guarantees no overflow; push+pop same cycle at full is legal, count unchanged; pop while empty impossible (resValid low).
REQ-019 err clears on start accepted in IDLE; otherwise sticky until reset.
REQ-020 DRAIN: sampleReady=0, results continue to be collected; FIFO contents persist into IDLE until popped.

Reset
REQ-021 On rstN low at posedge: state IDLE, coefs all 0, rawSensorVal 0, accelerateEn 0, inFlight 0, FIFO empty (resValid 0, resData 0), err 0, busy 0, sampleReady 0.
REQ-022 Reset mid-RUN discards in-flight samples and FIFO contents; results arriving after reset release are not counted (inFlight==0 -> REQ-016 applies).

Structure
REQ-023 Shared package fir_pkg holds DATA_WIDTH, NUM_REGS defaults and the state enum (IDLE, RUN, DRAIN); the accelerator and driver both import it.
REQ-024 One sub-module fir_res_fifo (parameterised width/depth, sync active-low reset, count output); all else in fir_driver.

Verification
REQ-025 coefs=[1,0,..0], start, samples 5,6,7 back-to-back, resReady=1 -> resData 5,6,7 in order; first resValid 3 cycles after first acceptance.
REQ-026 coefs all 1 (NUM_REGS=8), samples 1,2,3 -> results 1,3,6; err=0.
REQ-027 resReady=0, 6 samples offered -> exactly 4 accepted, sampleReady 0 thereafter; resReady=1 -> 4 results drained in order, remaining 2 accepted.
REQ-028 stop after 2nd of 3 samples -> DRAIN, sampleReady 0, 2 results delivered, then IDLE, busy 0.
REQ-029 coef write (addr 0, value 9) during RUN -> coefs[0] unchanged, err=1; start in IDLE clears err.
REQ-030 rstN low for 1 cycle mid-RUN with 2 samples in flight -> all outputs at REQ-021 values next cycle; late resultIsValid sets err, no resValid.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR driver and its accelerator: default sizes and
// the driver state encoding.
package fir_pkg;
    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_NUM_REGS   = 8;
    localparam int FIR_RES_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/fir_res_fifo.sv
// Small result FIFO with occupancy count; the read port shows zero while empty.
module fir_res_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             full, push_ok, pop_ok;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (int'(count) == DEPTH);
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= bump(wr_ptr);
            if (pop_ok)  rd_ptr <= bump(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fir_driver.sv
// Feeds a sample stream into the FIR accelerator, tracks outstanding results
// with a credit scheme and buffers returned results in a FIFO.
module fir_driver
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int NUM_REGS   = FIR_NUM_REGS,
    parameter int RES_DEPTH  = FIR_RES_DEPTH,
    localparam int AW = $clog2(NUM_REGS),
    localparam int CW = $clog2(RES_DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 rstN,
    input  logic                                 coefWrEn,
    input  logic [AW-1:0]                        coefAddr,
    input  logic [DATA_WIDTH-1:0]                coefData,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic                                 sampleValid,
    input  logic [DATA_WIDTH-1:0]                sampleData,
    output logic                                 sampleReady,
    output logic [DATA_WIDTH-1:0]                rawSensorVal,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  coefs,
    output logic                                 accelerateEn,
    input  logic [DATA_WIDTH-1:0]                macResult,
    input  logic                                 resultIsValid,
    output logic                                 resValid,
    output logic [DATA_WIDTH-1:0]                resData,
    input  logic                                 resReady,
    output logic                                 busy,
    output logic                                 err
);
    state_t        state;
    logic [CW-1:0] in_flight, fifo_count;
    logic [31:0]   addr_ext;
    logic          accept, counted, stray, coef_ok, coef_bad, fifo_empty;

    assign addr_ext = 32'(coefAddr);
    assign coef_ok  = coefWrEn && (state == IDLE) && (addr_ext < 32'(NUM_REGS));
    assign coef_bad = coefWrEn && !coef_ok;

    // Credits cover both queued results and those still inside the accelerator,
    // so every accepted sample is guaranteed a FIFO slot.
    assign sampleReady = (state == RUN) && (int'(fifo_count) + int'(in_flight) < RES_DEPTH);
    assign accept      = sampleValid && sampleReady;
    assign counted     = resultIsValid && (in_flight != '0);
    assign stray       = resultIsValid && (in_flight == '0);

    assign busy     = (state != IDLE);
    assign resValid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state        <= IDLE;
            coefs        <= '0;
            rawSensorVal <= '0;
            accelerateEn <= 1'b0;
            in_flight    <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (stop) state <= DRAIN;
                DRAIN:   if (in_flight == '0) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (coef_ok) coefs[coefAddr] <= coefData;

            // Idle cycles still clock a zero through the filter history.
            rawSensorVal <= accept ? sampleData : '0;
            accelerateEn <= accept;

            case ({accept, counted})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase

            if (start && state == IDLE) err <= 1'b0;
            else if (coef_bad || stray)  err <= 1'b1;
        end
    end

    fir_res_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rstN),
        .push  (counted),
        .wdata (macResult),
        .pop   (resValid && resReady),
        .rdata (resData),
        .empty (fifo_empty),
        .count (fifo_count)
    );
endmodule
